// File: rtl/pt_scan_pkg.sv
// Shared types and default printable-range limits for the plaintext scanner and the
// key-search controller.
package pt_scan_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLenIssue,
    StLenCap,
    StScan,
    StDone
  } pt_scan_state_t;

  localparam logic [7:0] PT_CHAR_LO = 8'h20;
  localparam logic [7:0] PT_CHAR_HI = 8'h7E;

endpackage

// File: rtl/pt_scan_char_range.sv
// Combinational inclusive range check of one character against [CHAR_LO, CHAR_HI].
module char_range #(
  parameter int unsigned       DATA_W  = 8,
  parameter logic [DATA_W-1:0] CHAR_LO = DATA_W'(8'h20),
  parameter logic [DATA_W-1:0] CHAR_HI = DATA_W'(8'h7E)
) (
  input  logic [DATA_W-1:0] data_i,
  output logic              in_range_o
);

  assign in_range_o = (data_i >= CHAR_LO) && (data_i <= CHAR_HI);

endmodule

// File: rtl/pt_scan.sv
// Length-prefixed plaintext scanner: checks one byte per clock against a printable range.
// Optional build macro PT_SCAN_EARLY_EXIT_EN stops the scan at the first illegal byte.
module pt_scan
  import pt_scan_pkg::*;
#(
  parameter int unsigned       ADDR_W  = 8,
  parameter int unsigned       DATA_W  = 8,
  parameter logic [DATA_W-1:0] CHAR_LO = DATA_W'(PT_CHAR_LO),
  parameter logic [DATA_W-1:0] CHAR_HI = DATA_W'(PT_CHAR_HI)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic              abort,
  input  logic [ADDR_W-1:0] base,
  output logic              rdy,
  output logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] rddata,
  output logic              valid,
  output logic              checked,
  output logic [DATA_W-1:0] bad_idx,
  output logic [DATA_W-1:0] bad_count,
  output logic [DATA_W-1:0] len
);

  pt_scan_state_t    state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  // One bit wider than the length so an all-ones length still terminates.
  logic [DATA_W:0]   idx_q, idx_d;
  logic [DATA_W-1:0] len_q, len_d;
  logic [DATA_W-1:0] bad_idx_q, bad_idx_d;
  logic [DATA_W-1:0] bad_count_q, bad_count_d;
  logic              valid_q, valid_d;
  logic              checked_q, checked_d;
  logic              byte_ok;

  char_range #(
    .DATA_W  (DATA_W),
    .CHAR_LO (CHAR_LO),
    .CHAR_HI (CHAR_HI)
  ) u_char_range (
    .data_i     (rddata),
    .in_range_o (byte_ok)
  );

  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    addr_d      = addr_q;
    idx_d       = idx_q;
    len_d       = len_q;
    bad_idx_d   = bad_idx_q;
    bad_count_d = bad_count_q;
    valid_d     = valid_q;
    checked_d   = checked_q;

    unique case (state_q)
      StIdle: begin
        if (en) begin
          base_d      = base;
          addr_d      = base;
          idx_d       = '0;
          len_d       = '0;
          bad_idx_d   = '0;
          bad_count_d = '0;
          valid_d     = 1'b0;
          checked_d   = 1'b0;
          state_d     = StLenIssue;
        end
      end
      StLenIssue: begin
        addr_d  = base_q + ADDR_W'(1);
        state_d = StLenCap;
      end
      StLenCap: begin
        len_d   = rddata;
        // addr is registered, so it runs one byte ahead of the byte being checked.
        addr_d  = base_q + ADDR_W'(2);
        idx_d   = (DATA_W+1)'(1);
        state_d = (rddata == '0) ? StDone : StScan;
      end
      StScan: begin
        addr_d = base_q + ADDR_W'(idx_q) + ADDR_W'(2);
        idx_d  = idx_q + (DATA_W+1)'(1);
        if (!byte_ok) begin
          if (bad_count_q != '1) begin
            bad_count_d = bad_count_q + DATA_W'(1);
          end
          if (bad_idx_q == '0) begin
            bad_idx_d = idx_q[DATA_W-1:0];
          end
        end
        if (idx_q == {1'b0, len_q}) begin
          state_d = StDone;
        end
`ifdef PT_SCAN_EARLY_EXIT_EN
        if (!byte_ok) begin
          state_d = StDone;
        end
`endif
      end
      StDone: begin
        checked_d = 1'b1;
        valid_d   = (bad_count_q == '0);
        state_d   = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Abort wins over any completion in the same cycle.
    if (abort && (state_q != StIdle)) begin
      state_d   = StIdle;
      valid_d   = 1'b0;
      checked_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      base_q      <= '0;
      addr_q      <= '0;
      idx_q       <= '0;
      len_q       <= '0;
      bad_idx_q   <= '0;
      bad_count_q <= '0;
      valid_q     <= 1'b0;
      checked_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      addr_q      <= addr_d;
      idx_q       <= idx_d;
      len_q       <= len_d;
      bad_idx_q   <= bad_idx_d;
      bad_count_q <= bad_count_d;
      valid_q     <= valid_d;
      checked_q   <= checked_d;
    end
  end

  assign rdy       = (state_q == StIdle);
  assign addr      = addr_q;
  assign valid     = valid_q;
  assign checked   = checked_q;
  assign bad_idx   = bad_idx_q;
  assign bad_count = bad_count_q;
  assign len       = len_q;

endmodule
